// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing
// with mem_ready wait states. Define MC_JUMP_EN to add the j instruction (JUMP state).
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
`ifdef MC_JUMP_EN
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;

  // DECODE dispatch; an unsupported opcode falls back to FETCH and is flagged illegal.
  function automatic logic [3:0] decode_next(input logic [5:0] opcode);
    logic [3:0] nxt;
    case (opcode)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
`ifdef MC_JUMP_EN
      OP_J:         nxt = S_JUMP;
`endif
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // State and latched-opcode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = decode_next(op);
        op_d    = op;
      end
      S_MEMADR: begin
        if (op_q == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op_q == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state (FETCH strobes gated by mem_ready).
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (decode_next(op) == S_FETCH) begin
          illegal_op = 1'b1;
        end else begin
          illegal_op = 1'b0;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
`endif
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS core. It sequences a shared single-ALU, single-memory datapath through fetch, decode, execute, memory and write-back steps. It supports R-type, lw, sw and beq, and j when that feature is compiled in. It replaces per-stage control-word decoding for the non-pipelined build. Memory access steps are held on a `mem_ready` handshake, so wait-state memories are supported.

## Interface
Parameters: none.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: opcode, `IR[31:26]`; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by ALU zero (datapath ANDs it).
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: load instruction register.
- `mem_to_reg` out 1: write-back select; 1 = MDR, 0 = ALUOut.
- `reg_dst` out 1: destination select; 1 = rd, 0 = rt.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6.
  - EXEC=7, ALUWB=8, BRANCH=9, JUMP=10; 11–15 are unused.
- IDLE: all outputs 0. Unconditional transition to FETCH.
- FETCH:
  - Always drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only in a cycle where `mem_ready`=1.
  - Advances to DECODE on `mem_ready`; otherwise stays in FETCH.
- DECODE: drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut). Next state by `op`:
  - 100011 or 101011 → MEMADR.
  - 000000 → EXEC.
  - 000100 → BRANCH.
  - 000010 → JUMP (only when enabled; see Configuration).
  - Any other opcode → FETCH, with `illegal_op` pulsed this cycle.
- MEMADR: drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Goes to MEMRD if the latched opcode is lw, or MEMWR if it is sw.
  - The opcode is latched in a 6-bit register on DECODE exit.
- MEMRD: drives `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: drives `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, and `instr_done`. Then FETCH.
- MEMWR: drives `mem_write`=1, `i_or_d`=1. Waits for `mem_ready`; pulses `instr_done` in that cycle; then FETCH.
- EXEC: drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Then ALUWB.
- ALUWB: drives `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, and `instr_done`. Then FETCH.
- BRANCH: drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, and `instr_done`. Then FETCH.
- JUMP: drives `pc_write`=1, `pc_source`=10, and `instr_done`. Then FETCH.
- Any output not listed for a state is 0 in that state.
- Unused state encodings go to IDLE on the next edge, with all outputs 0.

## Timing
- Reset:
  - On `rst`=1, the state goes to IDLE and the latched opcode to 0, immediately and asynchronously.
  - All outputs are 0 while reset is held, and `state`=0.
  - Reset asserted mid-instruction aborts the instruction; no write strobe is asserted after the reset edge.
- After reset release, the first rising edge moves to FETCH.
- Outputs are a function of the registered state. The only exceptions are `ir_write` and `pc_write` in FETCH, which are qualified combinationally by `mem_ready`.
- Cycle counts with zero wait states (`mem_ready` held 1), from FETCH entry to `instr_done` inclusive:
  - lw: 5.
  - sw, R-type: 4.
  - beq, j: 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Requests are held stable while waiting.
- `mem_ready` is ignored in all other states.
- `instr_done` and `illegal_op` are never high in the same cycle.

## Configuration
- `MC_JUMP_EN` defined:
  - Opcode 000010 goes DECODE → JUMP.
  - JUMP drives `pc_write`=1 and `pc_source`=10.
- `MC_JUMP_EN` undefined:
  - State 10 is not reachable, and is treated as an unused encoding.
  - Opcode 000010 is illegal: `illegal_op` pulses and the FSM returns to FETCH.
  - `pc_source` never takes the value 10.

## Test plan
- Reset with `mem_ready`=1, then release, `op`=000000 → `state` sequence 0,1,2,7,8,1. `alu_op`=10 in EXEC. `reg_write`=1 and `reg_dst`=1 and `instr_done`=1 in ALUWB only.
- `op`=100011 with `mem_ready` low for 2 cycles in MEMRD → 7 cycles FETCH→MEMWB. `mem_read`=1 and `i_or_d`=1 are held through the wait. MEMWB drives `mem_to_reg`=1 and `reg_dst`=0.
- `op`=101011 with `mem_ready` low for 3 cycles in FETCH → `ir_write`/`pc_write` pulse once, in the 4th FETCH cycle. MEMWR asserts `mem_write`=1 and pulses `instr_done`; `reg_write` stays 0 throughout.
- `op`=000100 → exactly 3 cycles. BRANCH drives `pc_write_cond`=1, `pc_source`=01, `alu_op`=01.
- `op`=111111 → `illegal_op`=1 for the DECODE cycle only; the next state is FETCH; no write strobes are asserted.
- `op`=000010: with `MC_JUMP_EN`, `pc_source`=10 and `pc_write`=1 in state 10. Without it, `illegal_op` pulses. Separately, assert `rst` during MEMWR → all outputs 0 immediately, state 0.
